// File: rtl/cpu_div_cell_if.sv
// Operand/result bundle between the E/M pipeline stages and the divider cell.
// Latency: none (wires only).
// Backpressure: none here; the pipeline stalls itself while M_div_busy is high.
interface cpu_div_cell_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] E_src1;
  logic [WIDTH-1:0] E_src2;
  logic             E_div_start;
  logic             E_div_signed;
  logic             M_div_busy;
  logic             M_div_done;
  logic [WIDTH-1:0] M_div_quot;
  logic [WIDTH-1:0] M_div_rem;

  // Pipeline side: drives operands and start, observes results.
  modport master (
    output E_src1, E_src2, E_div_start, E_div_signed,
    input  M_div_busy, M_div_done, M_div_quot, M_div_rem
  );

  // Divider side.
  modport slave (
    input  E_src1, E_src2, E_div_start, E_div_signed,
    output M_div_busy, M_div_done, M_div_quot, M_div_rem
  );
endinterface

// File: rtl/cpu_div_cell.sv
// Radix-2 restoring integer divider (signed/unsigned), one quotient bit per clock.
// Latency: done pulses in the cycle after edge WIDTH+1 from the start edge (edge 1 on early-out).
// Backpressure: none; starts are ignored while busy, the pipeline stalls on M_div_busy.
// Optional macro DIV_EARLY_OUT_EN: skip iteration for zero divisor or |dividend| < |divisor|.
module cpu_div_cell #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  cpu_div_cell_if.slave div_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;    // dividend magnitude, becomes the quotient magnitude
  logic [WIDTH-1:0] r_dsr;    // divisor magnitude
  logic [WIDTH-1:0] r_prem;   // partial remainder
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dz;

  logic             w_s1;
  logic             w_s2;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic             w_dz;
  logic             w_early;
  logic             w_accept;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic             w_last;
  logic             w_busy;
  logic             w_done;

  // Operand magnitudes and sign flags; unsigned mode passes raw values through.
  // The most-negative value maps to itself, which is its correct unsigned magnitude.
  assign w_s1   = div_if.E_div_signed & div_if.E_src1[WIDTH-1];
  assign w_s2   = div_if.E_div_signed & div_if.E_src2[WIDTH-1];
  assign w_mag1 = w_s1 ? -div_if.E_src1 : div_if.E_src1;
  assign w_mag2 = w_s2 ? -div_if.E_src2 : div_if.E_src2;
  assign w_dz   = (div_if.E_src2 == '0);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = w_dz | (w_mag1 < w_mag2);
`else
  assign w_early = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && div_if.E_div_start;

  // One restoring step: shift the next dividend bit into the partial remainder and
  // trial-subtract. A set top bit in the shifted value means it already exceeds any
  // WIDTH-bit divisor, so the subtraction always succeeds in that case.
  assign w_shift = {r_prem, r_dvd[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dsr};
  assign w_ge    = w_shift[WIDTH] | ~w_diff[WIDTH];
  assign w_last  = (r_cnt == LP_CNT_ONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status decode.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (div_if.E_div_start) begin
          w_state_nxt = w_early ? FIX : CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_nxt = FIX;
        end
      end
      FIX: begin
        w_state_nxt = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath and final sign fix-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_dsr  <= '0;
      r_prem <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dsr  <= w_mag2;
        r_qneg <= w_s1 ^ w_s2;
        r_rneg <= w_s1;
        r_dz   <= w_dz;
        if (w_early) begin
          // Quotient magnitude is zero and the remainder magnitude is the dividend;
          // the fix-up step restores the dividend's sign.
          r_dvd  <= '0;
          r_prem <= w_mag1;
          r_cnt  <= '0;
        end else begin
          r_dvd  <= w_mag1;
          r_prem <= '0;
          r_cnt  <= LP_CNT_INIT;
        end
      end else if (r_state == CALC) begin
        r_prem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_dvd  <= {r_dvd[WIDTH-2:0], w_ge};
        r_cnt  <= r_cnt - LP_CNT_ONE;
      end else if (r_state == FIX) begin
        // A zero divisor leaves the whole dividend magnitude in the partial
        // remainder, so the sign fix-up reproduces the original dividend; only the
        // quotient needs forcing to all ones.
        r_quot <= r_dz ? '1 : (r_qneg ? -r_dvd : r_dvd);
        r_rem  <= r_rneg ? -r_prem : r_prem;
      end
    end
  end

  assign div_if.M_div_busy = w_busy;
  assign div_if.M_div_done = w_done;
  assign div_if.M_div_quot = r_quot;
  assign div_if.M_div_rem  = r_rem;

endmodule

// File: tb/tb_cpu_div_cell.sv
// Self-checking bench for cpu_div_cell: directed cases plus randomized operations
// checked every cycle against a latency/arithmetic reference model.
module tb_cpu_div_cell;
  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int LAT_FULL = W + 1;
  localparam int LAT_EO   = EARLY ? 1 : W + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  cpu_div_cell_if #(.WIDTH(W)) dif ();

  cpu_div_cell #(.WIDTH(W), .CNT_W(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .div_if (dif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state
  bit          m_act = 1'b0;
  int          m_k   = 0;
  int          m_lat = 0;
  logic [31:0] m_q   = '0;
  logic [31:0] m_r   = '0;
  logic [31:0] p_q   = '0;
  logic [31:0] p_r   = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Architectural div/rem result
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sg) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic sg);
    logic [31:0] ma, mb;
    bit eo;
    ma = (sg && a[31]) ? (32'd0 - a) : a;
    mb = (sg && b[31]) ? (32'd0 - b) : b;
    eo = (b == 32'd0) || (ma < mb);
    return (EARLY && eo) ? 1 : LAT_FULL;
  endfunction

  // Model: an accepted start launches an op whose results appear lat edges later;
  // the done cycle is the last busy cycle.
  always @(posedge clk) begin
    if (reset) begin
      m_act = 1'b0;
      m_k   = 0;
      m_q   = '0;
      m_r   = '0;
    end else if (m_act) begin
      m_k++;
      if (m_k == m_lat) begin
        m_q = p_q;
        m_r = p_r;
      end
      if (m_k == m_lat + 1) m_act = 1'b0;
    end else if (dif.E_div_start) begin
      m_act = 1'b1;
      m_k   = 0;
      ref_div(dif.E_src1, dif.E_src2, dif.E_div_signed, p_q, p_r);
      m_lat = ref_lat(dif.E_src1, dif.E_src2, dif.E_div_signed);
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, dif.M_div_busy}, {31'b0, m_act});
      chk("done", {31'b0, dif.M_div_done}, {31'b0, (m_act && m_k == m_lat)});
      chk("quot", dif.M_div_quot, m_q);
      chk("rem",  dif.M_div_rem,  m_r);
    end
  end

  // Issue one op from a negedge, wait (bounded) for done, check latency and results.
  // Returns at the negedge of the first IDLE cycle after done.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                       input logic [31:0] eq, input logic [31:0] er, input int elat,
                       input bit noisy, input string nm);
    int n;
    bit seen;
    dif.E_src1       = a;
    dif.E_src2       = b;
    dif.E_div_signed = sg;
    dif.E_div_start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.E_div_start = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      if (dif.M_div_done) begin
        seen = 1'b1;
      end else begin
        if (noisy) begin
          dif.E_div_start  = ($urandom_range(0, 3) == 0);
          dif.E_src1       = $urandom;
          dif.E_src2       = $urandom;
          dif.E_div_signed = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        n++;
        @(negedge clk);
      end
    end
    chk({nm, "_lat"},  32'(n), 32'(elat));
    chk({nm, "_quot"}, dif.M_div_quot, eq);
    chk({nm, "_rem"},  dif.M_div_rem, er);
    if (noisy) dif.E_div_start = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    dif.E_div_start = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic sg;
    int dcnt;
    logic [31:0] dq, dr;

    dif.E_src1       = '0;
    dif.E_src2       = '0;
    dif.E_div_start  = 1'b0;
    dif.E_div_signed = 1'b0;
    reset            = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", {31'b0, dif.M_div_busy}, 32'd0);
    chk("rst_done", {31'b0, dif.M_div_done}, 32'd0);
    chk("rst_quot", dif.M_div_quot, 32'd0);
    chk("rst_rem",  dif.M_div_rem,  32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Directed cases with hand-computed results
    do_op(32'd100,        32'd7,        1'b0, 32'd14,        32'd2,         LAT_FULL, 1'b0, "u100_7");
    do_op(32'hFFFF_FF9C,  32'd7,        1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, LAT_FULL, 1'b0, "sm100_7");
    do_op(32'd100,        32'hFFFF_FFF9,1'b1, 32'hFFFF_FFF2, 32'd2,         LAT_FULL, 1'b0, "s100_m7");
    do_op(32'h1234_5678,  32'd0,        1'b0, 32'hFFFF_FFFF, 32'h1234_5678, LAT_EO,   1'b0, "udz");
    do_op(32'hFFFF_FFFB,  32'd0,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, LAT_EO,   1'b0, "sdz");
    do_op(32'h8000_0000,  32'hFFFF_FFFF,1'b1, 32'h8000_0000, 32'd0,         LAT_FULL, 1'b0, "sovf");
    do_op(32'd3,          32'd10,       1'b0, 32'd0,         32'd3,         LAT_EO,   1'b0, "u3_10");
    do_op(32'd10,         32'd0,        1'b0, 32'hFFFF_FFFF, 32'd10,        LAT_EO,   1'b0, "u10_0");

    // 5/3 with operand change at edge 5 and a second start at edge 10
    dif.E_src1       = 32'd5;
    dif.E_src2       = 32'd3;
    dif.E_div_signed = 1'b0;
    dif.E_div_start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.E_div_start = 1'b0;
    dcnt = 0;
    dq   = '0;
    dr   = '0;
    for (int e = 1; e <= 40; e++) begin
      if (e == 5)  dif.E_src1 = 32'd1000;
      if (e == 10) begin
        dif.E_div_start = 1'b1;
        dif.E_src1      = 32'd77;
        dif.E_src2      = 32'd2;
      end
      if (e == 11) dif.E_div_start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (dif.M_div_done) begin
        dcnt++;
        dq = dif.M_div_quot;
        dr = dif.M_div_rem;
      end
    end
    chk("ignore_done_cnt", 32'(dcnt), 32'd1);
    chk("ignore_quot", dq, 32'd1);
    chk("ignore_rem",  dr, 32'd2);

    // Reset at edge 20 of an operation
    dif.E_src1      = 32'd1000;
    dif.E_src2      = 32'd3;
    dif.E_div_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.E_div_start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", {31'b0, dif.M_div_busy}, 32'd0);
    chk("abort_done", {31'b0, dif.M_div_done}, 32'd0);
    chk("abort_quot", dif.M_div_quot, 32'd0);
    chk("abort_rem",  dif.M_div_rem,  32'd0);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
    end

    // Randomized operations, back-to-back or with small gaps
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 50));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = 32'($urandom_range(1, 20));
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      sg = 1'($urandom_range(0, 1));
      ref_div(a, b, sg, eq, er);
      do_op(a, b, sg, eq, er, ref_lat(a, b, sg), 1'(i % 2), "rnd");
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
